alu_exec_stage: RTL and testbench
=================================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 32, meaning operand/result width; only 32 is supported.
REQ-002 The block SHALL expose parameter SHAMT_W, default 5, meaning shift-amount width (log2 DATA_W).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port in_valid  input  1  upstream has an operation.
REQ-006 The block SHALL have port in_ready  output  1  stage can accept an operation this cycle.
REQ-007 The block SHALL have port alu_op  input  4  operation code per the ALUop.vh encoding (ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_COPY_B).
REQ-008 The block SHALL have port op_a  input  DATA_W  first operand.
REQ-009 The block SHALL have port op_b  input  DATA_W  second operand; for shifts, op_b[SHAMT_W-1:0] is the shift amount.
REQ-010 The block SHALL have port out_valid  output  1  result holds a completed operation.
REQ-011 The block SHALL have port out_ready  input  1  downstream consumes the result this cycle.
REQ-012 The block SHALL have port result  output  DATA_W  registered result.
REQ-013 The block SHALL have port busy  output  1  high while state is SHIFT.

Function
REQ-014 Acceptance SHALL occur on a rising edge where in_valid && in_ready; inputs are sampled only then.
REQ-015 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready), combinationally.
REQ-016 Handshake: out_valid and result SHALL hold stable until an edge with out_valid && out_ready; that edge clears out_valid unless a new result is written on the same edge.
REQ-017 Simultaneous consume and accept of a non-shift op SHALL leave out_valid high with the new result (full throughput, one op per cycle).
REQ-018 Non-shift ops SHALL write result at the accepting edge; out_valid high the following cycle (latency 1).
REQ-019 ADD/SUB SHALL be modulo 2^DATA_W; SLT signed and SLTU unsigned compare, yielding 0 or 1; COPY_B yields op_b; bitwise ops per name.
REQ-020 Shifts SHALL use only op_b[4:0]; SRA sign-fills from op_a[31], SRL/SLL zero-fill.
REQ-021 An unrecognised alu_op SHALL produce result 0 with normal latency 1.
REQ-022 State machine SHALL have states IDLE and SHIFT; SHIFT exists only when SERIAL_SHIFT_EN is defined (REQ-027).
REQ-023 In SHIFT, in_ready SHALL be 0 and further in_valid SHALL be ignored.

Reset
REQ-024 On reset_n low, state SHALL go to IDLE immediately (asynchronous), out_valid=0, result=0, busy=0, shift counter=0.
REQ-025 Reset asserted mid-SHIFT SHALL abort the operation; no result is produced after deassert.
REQ-026 After reset_n deasserts, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-027 Macro SERIAL_SHIFT_EN: when defined, a shift with amount s>=1 SHALL load op_a and s at the accepting edge, enter SHIFT, shift one bit per edge, decrement the counter, and write result and return to IDLE on the edge where the counter reaches 0 (result at edge s after acceptance; out_valid high s+1 cycles after acceptance); s=0 SHALL behave as a non-shift op (result=op_a, latency 1).
REQ-028 When SERIAL_SHIFT_EN is not defined, all shifts SHALL use a single-cycle barrel shifter with latency 1, busy SHALL be tied 0, and no SHIFT state SHALL be built.

Verification
REQ-029 ALU_ADD, op_a=0xFFFFFFFF, op_b=0x00000002, out_ready=1 -> result=0x00000001, out_valid high 1 cycle after accept.
REQ-030 ALU_SLT op_a=0xFFFFFFFF, op_b=1 -> result=1; ALU_SLTU same operands -> result=0.
REQ-031 SERIAL_SHIFT_EN defined, ALU_SRA op_a=0x80000000, op_b=0x00000024 (s=4) -> busy 4 cycles, in_ready low, result=0xF8000000 at 5th cycle after accept.
REQ-032 out_ready=0 with out_valid=1 for 3 cycles -> result stable, in_ready=0, a pending in_valid not accepted; out_ready=1 -> consume and accept same edge, back-to-back results.
REQ-033 reset_n pulsed low during SHIFT with s=10 -> out_valid=0, result=0 immediately, no stale result after release, in_ready=1 next cycle.

Source files
------------

// File: rtl/alu_exec_stage.sv
// alu_exec_stage -- single-issue ALU execute stage with a valid/ready
// handshake on both sides and one registered result slot.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous, active-low reset
//   in_valid   upstream presents an operation
//   in_ready   stage accepts an operation this cycle
//   alu_op     4-bit ALU opcode (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA,
//              OR, AND, COPY_B; other codes yield 0)
//   op_a       first operand
//   op_b       second operand; op_b[SHAMT_W-1:0] is the shift amount
//   out_valid  result holds a completed operation
//   out_ready  downstream consumes the result this cycle
//   result     registered result
//   busy       high while a serial shift is in progress
//
// Build option
//   SERIAL_SHIFT_EN  when defined, shifts by s>=1 run one bit per cycle in a
//                    SHIFT state; otherwise a single-cycle barrel shifter is
//                    used, busy is tied low and no SHIFT state exists.
module alu_exec_stage #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              busy
);

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_COPY_B = 4'd10;

  // Single-cycle result for every opcode; shifts here are barrel shifts.
  function automatic logic [DATA_W-1:0] alu_compute(
    input logic [3:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic        [SHAMT_W-1:0] shamt;
    logic        [DATA_W-1:0] r;
    a_s   = a;
    b_s   = b;
    shamt = b[SHAMT_W-1:0];
    case (op)
      ALU_ADD:    r = a + b;
      ALU_SUB:    r = a - b;
      ALU_SLL:    r = a << shamt;
      ALU_SLT:    r = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU:   r = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_XOR:    r = a ^ b;
      ALU_SRL:    r = a >> shamt;
      ALU_SRA:    r = a_s >>> shamt;
      ALU_OR:     r = a | b;
      ALU_AND:    r = a & b;
      ALU_COPY_B: r = b;
      default:    r = '0;
    endcase
    return r;
  endfunction

  logic accept;
  assign accept = in_valid && in_ready;

`ifdef SERIAL_SHIFT_EN

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state;
  logic [SHAMT_W-1:0]  shift_cnt;
  logic [DATA_W-1:0]   shift_val;
  logic [DATA_W-1:0]   shift_next;
  logic [3:0]          shift_op;
  logic                is_shift;
  logic [SHAMT_W-1:0]  shamt_in;

  assign shamt_in = op_b[SHAMT_W-1:0];
  assign is_shift = (alu_op == ALU_SLL) || (alu_op == ALU_SRL) || (alu_op == ALU_SRA);
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);

  // One-bit step of the shift in flight.
  always_comb begin
    shift_next = shift_val >> 1;
    if (shift_op == ALU_SLL) begin
      shift_next = shift_val << 1;
    end else if (shift_op == ALU_SRA) begin
      shift_next = {shift_val[DATA_W-1], shift_val[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      shift_cnt <= '0;
      shift_val <= '0;
      shift_op  <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else if (state == SHIFT) begin
      // out_valid is already low here: entering SHIFT required a free slot.
      shift_val <= shift_next;
      shift_cnt <= shift_cnt - SHAMT_W'(1);
      if (shift_cnt == SHAMT_W'(1)) begin
        result    <= shift_next;
        out_valid <= 1'b1;
        busy      <= 1'b0;
        state     <= IDLE;
      end
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (is_shift && (shamt_in != '0)) begin
          shift_val <= op_a;
          shift_cnt <= shamt_in;
          shift_op  <= alu_op;
          busy      <= 1'b1;
          state     <= SHIFT;
        end else begin
          // A zero-distance shift falls through here and returns op_a.
          result    <= alu_compute(alu_op, op_a, op_b);
          out_valid <= 1'b1;
        end
      end
    end
  end

`else

  assign in_ready = !out_valid || out_ready;
  assign busy     = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      // A new accept on the consuming edge keeps out_valid high.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        result    <= alu_compute(alu_op, op_a, op_b);
        out_valid <= 1'b1;
      end
    end
  end

`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_COPY_B = 4'd10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    alu_op   = op;
    op_a     = a;
    op_b     = b;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, ALU_ADD, 32'h0, 32'h0);
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %h exp 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy); end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %h exp 1", in_ready); end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  ops  [12] = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_SLT, ALU_SLTU,
                               ALU_XOR, ALU_OR, ALU_AND, ALU_COPY_B, 4'hF, 4'hB};
    logic [31:0] as   [12] = '{32'hFFFFFFFF, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h1,
                               32'hF0F0A5A5, 32'h12340000, 32'hF0F0A5A5, 32'hDEADBEEF, 32'h12345678, 32'h1};
    logic [31:0] bs   [12] = '{32'h2, 32'h7, 32'h1, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'h0FF05A5A, 32'h00005678, 32'h0FF0FF00, 32'h0BADF00D, 32'h1, 32'h1};
    logic [31:0] exps [12] = '{32'h1, 32'hFFFFFFFE, 32'h1, 32'h0, 32'h0, 32'h1,
                               32'hFF00FFFF, 32'h12345678, 32'h00F0A500, 32'h0BADF00D, 32'h0, 32'h0};
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, ops[i], as[i], bs[i]);
      @(posedge clk); #1;
      drive(1'b0, ALU_ADD, 32'h0, 32'h0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL op%0d_latency out_valid got %h exp 1", i, out_valid); end
      checks++; if (result !== exps[i]) begin errors++; $display("FAIL op%0d_result got %h exp %h", i, result, exps[i]); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL op%0d_consumed out_valid got %h exp 0", i, out_valid); end
    end
  endtask

  task automatic test_shifts();
    logic [3:0]  ops  [7] = '{ALU_SLL, ALU_SRL, ALU_SRA, ALU_SRA, ALU_SLL, ALU_SRL, ALU_SRA};
    logic [31:0] as   [7] = '{32'h1, 32'h80000000, 32'h80000000, 32'h7FFFFFF0, 32'h3, 32'hA5A5A5A5, 32'hF0000000};
    logic [31:0] bs   [7] = '{32'h24, 32'h24, 32'h24, 32'hFFFFFFE4, 32'h1F, 32'h20, 32'h1F};
    logic [31:0] exps [7] = '{32'h10, 32'h08000000, 32'hF8000000, 32'h07FFFFFF, 32'h80000000, 32'hA5A5A5A5, 32'hFFFFFFFF};
    int waited;
    int exp_wait;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
`ifdef SERIAL_SHIFT_EN
      exp_wait = int'(bs[i][4:0]);
`else
      exp_wait = 0;
`endif
      drive(1'b1, ops[i], as[i], bs[i]);
      @(posedge clk); #1;
      drive(1'b0, ALU_ADD, 32'h0, 32'h0);
      waited = 0;
      while (out_valid !== 1'b1 && waited < 40) begin
        @(posedge clk); #1;
        waited++;
      end
      checks++; if (waited !== exp_wait) begin errors++; $display("FAIL shift%0d_latency waited %0d exp %0d", i, waited, exp_wait); end
      checks++; if (result !== exps[i]) begin errors++; $display("FAIL shift%0d_result got %h exp %h", i, result, exps[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, ALU_ADD, 32'h1, 32'h2);
    @(posedge clk); #1;
    drive(1'b1, ALU_SUB, 32'hA, 32'h4);
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold%0d_out_valid got %h exp 1", i, out_valid); end
      checks++; if (result !== 32'h3) begin errors++; $display("FAIL hold%0d_result got %h exp 3", i, result); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold%0d_in_ready got %h exp 0", i, in_ready); end
      @(posedge clk); #1;
    end
    checks++; if (result !== 32'h3) begin errors++; $display("FAIL hold_end_result got %h exp 3", result); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %h exp 1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL swap_out_valid got %h exp 1", out_valid); end
    checks++; if (result !== 32'h6) begin errors++; $display("FAIL swap_result got %h exp 6", result); end
    drive(1'b0, ALU_ADD, 32'h0, 32'h0);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid got %h exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops  [5] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_COPY_B};
    logic [31:0] as   [5] = '{32'h10, 32'h0, 32'hFF00FF00, 32'h1, 32'h0};
    logic [31:0] bs   [5] = '{32'h20, 32'h1, 32'h0F0F0F0F, 32'h2, 32'h55};
    logic [31:0] exps [5] = '{32'h30, 32'hFFFFFFFF, 32'h0F000F00, 32'h3, 32'h55};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ops[i], as[i], bs[i]);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_in_ready got %h exp 1", i, in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b%0d_out_valid got %h exp 1", i, out_valid); end
      checks++; if (result !== exps[i]) begin errors++; $display("FAIL b2b%0d_result got %h exp %h", i, result, exps[i]); end
    end
    drive(1'b0, ALU_ADD, 32'h0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    drive(1'b1, ALU_ADD, 32'h7, 32'h8);
    @(posedge clk); #1;
    drive(1'b0, ALU_ADD, 32'h0, 32'h0);
    checks++; if (result !== 32'hF) begin errors++; $display("FAIL pre_reset_result got %h exp f", result); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid got %h exp 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL async_result got %h exp 0", result); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %h exp 1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got %h exp 0", out_valid); end
    out_ready = 1'b1;
  endtask

`ifdef SERIAL_SHIFT_EN
  task automatic test_serial_sra();
    out_ready = 1'b1;
    drive(1'b1, ALU_SRA, 32'h80000000, 32'h24);
    @(posedge clk); #1;
    drive(1'b1, ALU_ADD, 32'h1, 32'h1);
    for (int i = 0; i < 4; i++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sra_busy%0d got %h exp 1", i, busy); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sra_in_ready%0d got %h exp 0", i, in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sra_out_valid%0d got %h exp 0", i, out_valid); end
      if (i == 3) drive(1'b0, ALU_ADD, 32'h0, 32'h0);
      @(posedge clk); #1;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sra_done_out_valid got %h exp 1", out_valid); end
    checks++; if (result !== 32'hF8000000) begin errors++; $display("FAIL sra_done_result got %h exp f8000000", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sra_done_busy got %h exp 0", busy); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sra_ignored_op out_valid got %h exp 0", out_valid); end
  endtask

  task automatic test_serial_reset();
    logic stale;
    out_ready = 1'b1;
    drive(1'b1, ALU_SRA, 32'h80000000, 32'h0A);
    @(posedge clk); #1;
    drive(1'b0, ALU_ADD, 32'h0, 32'h0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sreset_busy_before got %h exp 1", busy); end
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sreset_out_valid got %h exp 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL sreset_result got %h exp 0", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sreset_busy got %h exp 0", busy); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sreset_in_ready got %h exp 1", in_ready); end
    stale = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1;
    end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL sreset_stale got %h exp 0", stale); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_ops();
    test_shifts();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
`ifdef SERIAL_SHIFT_EN
    test_serial_sra();
    test_serial_reset();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
